board_renderer: RTL



---
 rtl/board_renderer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - 3-stage checkers-board pixel renderer with frame-synchronised board snapshot
// Optional king-dot rendering enabled by defining BOARD_RENDERER_KING_EN.
module board_renderer #(
    parameter int BOARD_DIM    = 8,
    parameter int SQUARE_PX    = 60,
    parameter int X_OFFSET     = 80,
    parameter int Y_OFFSET     = 0,
    parameter int RADIUS       = 25,
    parameter int RING_PX      = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [BOARD_DIM*BOARD_DIM*4-1:0] board_in,
    input  logic                             board_load,
    output logic                             board_ack,
    input  logic                             frame_start,
    input  logic                             pix_valid,
    input  logic [9:0]                       x,
    input  logic [8:0]                       y,
    output logic                             out_valid,
    output logic [7:0]                       r,
    output logic [7:0]                       g,
    output logic [7:0]                       b
);
    localparam int BW   = BOARD_DIM * BOARD_DIM * 4;
    localparam int CW   = (BOARD_DIM > 1) ? $clog2(BOARD_DIM) : 1;
    localparam int OW   = (SQUARE_PX > 1) ? $clog2(SQUARE_PX) : 1;
    localparam int HALF = SQUARE_PX / 2;
    localparam int D2W  = $clog2(HALF * HALF * 2 + 1) + 1;
    localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int R2   = RADIUS * RADIUS;
    localparam int RR2  = (RADIUS + RING_PX) * (RADIUS + RING_PX);
    localparam int BPX  = BOARD_DIM * SQUARE_PX;

    logic [BW-1:0] shadow, active;
    logic          pending;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    // Combined load+frame_start bypasses the shadow so the new board is active immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow    <= '0;
            active    <= '0;
            pending   <= 1'b0;
            board_ack <= 1'b0;
        end else begin
            board_ack <= 1'b0;
            if (board_load && frame_start) begin
                shadow    <= board_in;
                active    <= board_in;
                pending   <= 1'b0;
                board_ack <= 1'b1;
            end else if (board_load) begin
                shadow  <= board_in;
                pending <= 1'b1;
            end else if (frame_start && pending) begin
                active    <= shadow;
                pending   <= 1'b0;
                board_ack <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (int'(frame_cnt) == BLINK_FRAMES - 1) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Stage 1: board-square decode
    logic [9:0]    xd;
    logic [8:0]    yd;
    logic          on_board;
    logic          s1_valid, s1_on;
    logic [CW-1:0] s1_col, s1_row;
    logic [OW-1:0] s1_xo, s1_yo;

    always_comb begin
        xd       = x - 10'(X_OFFSET);
        yd       = y - 9'(Y_OFFSET);
        on_board = (int'(x) >= X_OFFSET) && (int'(x) < X_OFFSET + BPX) &&
                   (int'(y) >= Y_OFFSET) && (int'(y) < Y_OFFSET + BPX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_on    <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_xo    <= '0;
            s1_yo    <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_on    <= on_board;
            s1_col   <= CW'(xd / 10'(SQUARE_PX));
            s1_row   <= CW'(yd / 9'(SQUARE_PX));
            s1_xo    <= OW'(xd % 10'(SQUARE_PX));
            s1_yo    <= OW'(yd % 9'(SQUARE_PX));
        end
    end

    // Stage 2: cell fetch from the active snapshot and squared distance to square centre
    int             dx, dy, idx;
    logic [D2W-1:0] d2;
    logic           s2_valid, s2_on, s2_par, s2_blink;
    logic           s2_occ, s2_red, s2_sel;
    logic [D2W-1:0] s2_d2;
`ifdef BOARD_RENDERER_KING_EN
    logic           s2_king;
`endif

    always_comb begin
        dx  = int'(s1_xo) - HALF;
        dy  = int'(s1_yo) - HALF;
        d2  = D2W'(dx * dx + dy * dy);
        idx = s1_on ? (int'(s1_row) * BOARD_DIM + int'(s1_col)) : 0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_on    <= 1'b0;
            s2_par   <= 1'b0;
            s2_blink <= 1'b0;
            s2_occ   <= 1'b0;
            s2_red   <= 1'b0;
            s2_sel   <= 1'b0;
            s2_d2    <= '0;
`ifdef BOARD_RENDERER_KING_EN
            s2_king  <= 1'b0;
`endif
        end else begin
            s2_valid <= s1_valid;
            s2_on    <= s1_on;
            s2_par   <= s1_col[0] ^ s1_row[0];
            s2_blink <= blink_phase;
            s2_occ   <= s1_on & active[idx*4];
            s2_red   <= s1_on & active[idx*4+1];
            s2_sel   <= s1_on & active[idx*4+3];
            s2_d2    <= d2;
`ifdef BOARD_RENDERER_KING_EN
            s2_king  <= s1_on & active[idx*4+2];
`endif
        end
    end

    // Stage 3: colour priority
    logic [23:0] colour;
    logic        king_dot;

    always_comb begin
`ifdef BOARD_RENDERER_KING_EN
        king_dot = s2_king && (int'(s2_d2) <= (RADIUS / 3) * (RADIUS / 3));
`else
        king_dot = 1'b0;
`endif
        if (!s2_on)
            colour = 24'h000000;
        else if (s2_occ && int'(s2_d2) <= R2)
            colour = king_dot ? 24'hFFD700 : (s2_red ? 24'hFF0000 : 24'h00FF00);
        else if (s2_sel && s2_blink && int'(s2_d2) > R2 && int'(s2_d2) <= RR2)
            colour = 24'hFFFF00;
        else
            colour = s2_par ? 24'hFFFFFF : 24'h000000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                r <= colour[23:16];
                g <= colour[15:8];
                b <= colour[7:0];
            end
        end
    end
endmodule
